// File: rtl/posit_fault_pkg.sv
// Shared definitions for the posit fault responder: FSM state encoding and default sizes.
package posit_fault_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    EVAL = ST_EVAL,
    HOLD = ST_HOLD
  } state_t;

endpackage

// File: rtl/posit_fault_responder_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import posit_fault_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/posit_fault_responder.sv
// Sequences one operand pair through the posit adder fault checker and returns a
// single (optionally repaired) result, keeping saturating op/fault statistics.
module posit_fault_responder
  import posit_fault_pkg::*;
#(
  parameter int FULL_NBITS  = 32,
  parameter int TRUNC_NBITS = 16,
  parameter int ES          = 2,
  parameter int CHK_LAT     = 1,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FULL_NBITS-1:0] in_a,
  input  logic [FULL_NBITS-1:0] in_b,
  output logic [FULL_NBITS-1:0] chk_a,
  output logic [FULL_NBITS-1:0] chk_b,
  input  logic                  chk_fault,
  input  logic                  chk_mode,
  input  logic [FULL_NBITS-1:0] chk_true_sum,
  input  logic [FULL_NBITS-1:0] chk_used_sum,
  input  logic                  repair_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FULL_NBITS-1:0] out_sum,
  output logic                  out_fault,
  output logic                  out_mode,
  output logic                  chk_incons,
  output logic [CNT_W-1:0]      op_cnt,
  output logic [CNT_W-1:0]      fault_cnt,
  input  logic                  clr_cnt
);

  // Truncated width and ES only shape the checker; reject nonsense configurations.
  if (TRUNC_NBITS > FULL_NBITS || ES >= TRUNC_NBITS || CHK_LAT < 0) begin : g_bad_cfg
    $error("posit_fault_responder: inconsistent parameters");
  end

  localparam int WW = (CHK_LAT > 1) ? $clog2(CHK_LAT + 1) : 1;

  state_t        state;
  logic [WW-1:0] wcnt;
  logic          out_hs;

  assign in_ready = (state == IDLE);
  assign out_hs   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      chk_a     <= '0;
      chk_b     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_fault <= 1'b0;
      out_mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          chk_a <= in_a;
          chk_b <= in_b;
          wcnt  <= WW'(CHK_LAT);
          state <= (CHK_LAT == 0) ? EVAL : WAIT;
        end
        WAIT: begin
          wcnt <= wcnt - WW'(1);
          if (wcnt <= WW'(1)) state <= EVAL;
        end
        EVAL: begin
          out_sum   <= (chk_fault && repair_en) ? chk_true_sum : chk_used_sum;
          out_fault <= chk_fault;
          out_mode  <= chk_mode;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A clean fault flag paired with diverging sums means the checker itself is suspect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      chk_incons <= 1'b0;
    else if (clr_cnt)
      chk_incons <= 1'b0;
    else if (state == EVAL && !chk_fault && chk_true_sum != chk_used_sum)
      chk_incons <= 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_op_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_hs),
    .clr   (clr_cnt),
    .cnt   (op_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fault_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_hs & out_fault),
    .clr   (clr_cnt),
    .cnt   (fault_cnt)
  );

endmodule

// File: tb/tb_posit_fault_responder.sv
// Scoreboard bench for posit_fault_responder: expected results queued at accept,
// compared at the output handshake; counters tracked by a small saturating model.
module tb_posit_fault_responder;

  localparam int FN = 32;
  localparam int CL = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [FN-1:0] in_a, in_b;
  logic [FN-1:0] chk_a, chk_b;
  logic          chk_fault, chk_mode;
  logic [FN-1:0] chk_true_sum, chk_used_sum;
  logic          repair_en;
  logic          out_valid;
  logic          out_ready;
  logic [FN-1:0] out_sum;
  logic          out_fault, out_mode;
  logic          chk_incons;
  logic [CW-1:0] op_cnt, fault_cnt;
  logic          clr_cnt;

  posit_fault_responder #(
    .FULL_NBITS(FN), .TRUNC_NBITS(16), .ES(2), .CHK_LAT(CL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .chk_a(chk_a), .chk_b(chk_b),
    .chk_fault(chk_fault), .chk_mode(chk_mode),
    .chk_true_sum(chk_true_sum), .chk_used_sum(chk_used_sum),
    .repair_en(repair_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_fault(out_fault), .out_mode(out_mode),
    .chk_incons(chk_incons), .op_cnt(op_cnt), .fault_cnt(fault_cnt),
    .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FN-1:0] sum;
    logic          fault;
    logic          mode;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            n_chk  = 0;
  int            n_pass = 0;
  logic [CW-1:0] m_op    = '0;
  logic [CW-1:0] m_fault = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Output side: pop and compare on every handshake; track counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_op    = '0;
      m_fault = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_result", 64'(1), 64'(0));
        else begin
          e = sb.pop_front();
          check("out_sum", 64'(out_sum), 64'(e.sum));
          check("out_fault", 64'(out_fault), 64'(e.fault));
          check("out_mode", 64'(out_mode), 64'(e.mode));
        end
        if (!clr_cnt) begin
          if (m_op != '1) m_op = m_op + CW'(1);
          if (e.fault && m_fault != '1) m_fault = m_fault + CW'(1);
        end
      end
      if (clr_cnt) begin
        m_op    = '0;
        m_fault = '0;
      end
    end
  end

  // Offer one pair from IDLE, queue the expected result, check operand latch and latency.
  task automatic send(input logic [FN-1:0] a, input logic [FN-1:0] b,
                      input logic f, input logic m,
                      input logic [FN-1:0] t, input logic [FN-1:0] u,
                      input logic rep, input logic [FN-1:0] exp_sum);
    int lat;
    @(posedge clk); #1;
    chk_fault = f; chk_mode = m; chk_true_sum = t; chk_used_sum = u; repair_en = rep;
    in_a = a; in_b = b; in_valid = 1'b1;
    sb.push_back('{sum: exp_sum, fault: f, mode: m});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("chk_a", 64'(chk_a), 64'(a));
    check("chk_b", 64'(chk_b), 64'(b));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_latency", 64'(lat), 64'(1 + CL));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("return_to_idle", 64'(in_ready), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    chk_fault = 1'b0; chk_mode = 1'b0; chk_true_sum = '0; chk_used_sum = '0;
    repair_en = 1'b1; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_op_cnt", 64'(op_cnt), 64'(0));
    check("rst_fault_cnt", 64'(fault_cnt), 64'(0));
    check("rst_chk_a", 64'(chk_a), 64'(0));
    check("rst_incons", 64'(chk_incons), 64'(0));

    // No fault
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4800_0000, 32'h4800_0000, 1'b1, 32'h4800_0000);
    wait_idle();
    check("nofault_op_cnt", 64'(op_cnt), 64'(1));
    check("nofault_fault_cnt", 64'(fault_cnt), 64'(0));

    // Fault, repaired
    send(32'h4000_0000, 32'h4000_0000, 1'b1, 1'b1, 32'h4800_0000, 32'h47F0_0000, 1'b1, 32'h4800_0000);
    wait_idle();
    check("repair_fault_cnt", 64'(fault_cnt), 64'(1));

    // Fault, repair disabled
    send(32'h4000_0000, 32'h4000_0000, 1'b1, 1'b1, 32'h4800_0000, 32'h47F0_0000, 1'b0, 32'h47F0_0000);
    wait_idle();
    check("norepair_fault_cnt", 64'(fault_cnt), 64'(2));
    check("norepair_op_cnt", 64'(op_cnt), 64'(3));

    // Backpressure: result must hold and new offers be ignored
    out_ready = 1'b0;
    send(32'h3C00_0000, 32'h4400_0000, 1'b0, 1'b1, 32'h5000_0000, 32'h5000_0000, 1'b1, 32'h5000_0000);
    in_valid = 1'b1; in_a = 32'h1111_1111; in_b = 32'h2222_2222;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_out_sum", 64'(out_sum), 64'h5000_0000);
      check("bp_out_mode", 64'(out_mode), 64'(1));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_chk_a", 64'(chk_a), 64'h3C00_0000);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("bp_op_cnt", 64'(op_cnt), 64'(4));

    // Checker inconsistency: sticky until clr_cnt
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4800_0000, 32'h47F0_0000, 1'b1, 32'h47F0_0000);
    wait_idle();
    check("incons_set", 64'(chk_incons), 64'(1));
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4800_0000, 32'h4800_0000, 1'b1, 32'h4800_0000);
    wait_idle();
    check("incons_sticky", 64'(chk_incons), 64'(1));
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("incons_clr", 64'(chk_incons), 64'(0));
    check("clr_op_cnt", 64'(op_cnt), 64'(0));

    // Saturation: 17 ops into a 4-bit counter, faults on odd ops
    for (int i = 0; i < 17; i++) begin
      logic [FN-1:0] t, u, x;
      logic f, rep;
      f   = (i % 2) == 1;
      rep = (i % 4) < 2;
      t   = $urandom;
      u   = f ? (t ^ 32'h0000_0100) : t;
      x   = (f && rep) ? t : u;
      send($urandom, $urandom, f, (i % 3) == 0, t, u, rep, x);
      wait_idle();
    end
    check("sat_op_cnt", 64'(op_cnt), 64'hF);
    check("sat_fault_cnt", 64'(fault_cnt), 64'(8));
    check("sat_fault_model", 64'(fault_cnt), 64'(m_fault));

    // Clear in the same cycle as a handshake
    out_ready = 1'b0;
    send(32'h4000_0000, 32'h4000_0000, 1'b1, 1'b0, 32'h4800_0000, 32'h47F0_0000, 1'b1, 32'h4800_0000);
    out_ready = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("clrhs_op_cnt", 64'(op_cnt), 64'(0));
    check("clrhs_fault_cnt", 64'(fault_cnt), 64'(0));
    check("clrhs_out_valid", 64'(out_valid), 64'(0));
    check("clrhs_op_model", 64'(op_cnt), 64'(m_op));

    // Reset in the middle of WAIT: operation discarded, nothing counted
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4800_0000, 32'h4800_0000, 1'b1, 32'h4800_0000);
    wait_idle();
    check("pre_rst_op_cnt", 64'(op_cnt), 64'(1));
    @(posedge clk); #1;
    in_a = 32'h5555_5555; in_b = 32'h6666_6666; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("midwait_chk_a", 64'(chk_a), 64'h5555_5555);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_chk_a", 64'(chk_a), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_out_valid", 64'(out_valid), 64'(0));
    end
    check("post_rst_op_cnt", 64'(op_cnt), 64'(0));
    check("post_rst_fault_cnt", 64'(fault_cnt), 64'(0));
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
